// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the fetch PC, the single-outstanding imem
// handshake, redirect/stall handling and the IF/ID output register.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic [31:0] pc,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] redirect_pc;
    logic [31:0] pc_inc;

    // Handshake: imem_req is the valid, imem_ack the completion; a request is
    // held with a stable address until the cycle in which imem_ack is sampled high.
    assign imem_req   = (state_q == ST_REQ) || (state_q == ST_DROP);
    assign imem_addr  = (state_q == ST_DROP) ? drop_addr_q : pc_q;
    assign flush_ifid = br_taken;
    assign flush_idex = br_taken;
    assign if_valid   = if_valid_q;
    assign if_pc      = if_pc_q;
    assign if_inst    = if_inst_q;
    assign pc         = pc_q;
    assign dbg_state  = state_q;

    assign redirect_pc = br_target & ~32'h0000_0003;
    assign pc_inc      = pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_addr_d  = drop_addr_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_inst_d    = if_inst_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_inst_d  = skid_inst_q;

        if (br_taken) begin
            pc_d         = redirect_pc;
            if_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
            // An unanswered request must still be retired, so remember its address.
            if (imem_req && !imem_ack) begin
                state_d = ST_DROP;
                if (state_q == ST_REQ) begin
                    drop_addr_d = pc_q;
                end
            end else begin
                state_d = ST_REQ;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_REQ;
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        pc_d = pc_inc;
                        if (stall) begin
                            skid_valid_d = 1'b1;
                            skid_pc_d    = pc_q;
                            skid_inst_d  = imem_rdata;
                            state_d      = ST_HOLD;
                        end else begin
                            if_valid_d = 1'b1;
                            if_pc_d    = pc_q;
                            if_inst_d  = imem_rdata;
                        end
                    end else if (!stall) begin
                        if_valid_d = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        if_valid_d   = skid_valid_q;
                        if_pc_d      = skid_pc_q;
                        if_inst_d    = skid_inst_q;
                        skid_valid_d = 1'b0;
                        state_d      = ST_REQ;
                    end
                end
                default: begin
                    if_valid_d = 1'b0;
                    if (imem_ack) begin
                        state_d = ST_REQ;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            drop_addr_q  <= 32'h0;
            if_valid_q   <= 1'b0;
            if_pc_q      <= 32'h0;
            if_inst_q    <= 32'h0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= 32'h0;
            skid_inst_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_addr_q  <= drop_addr_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_inst_q    <= if_inst_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_inst_q  <= skid_inst_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a latency-programmable memory responder.
module tb_fetch_sequencer;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        flush_ifid;
    logic        flush_idex;
    logic [31:0] pc;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int lat = 1;
    int cnt = 0;

    fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rstn(rstn), .br_taken(br_taken), .br_target(br_target),
        .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .if_pc(if_pc), .if_inst(if_inst), .flush_ifid(flush_ifid),
        .flush_idex(flush_idex), .pc(pc), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // Memory: acks the lat-th cycle a request has been held (lat=1 is zero-wait).
    always @(negedge clk) begin
        if (!rstn || !imem_req) begin
            imem_ack   = 1'b0;
            imem_rdata = 32'h0;
            cnt        = 0;
        end else if (cnt == lat - 1) begin
            imem_ack   = 1'b1;
            imem_rdata = mem(imem_addr);
            cnt        = 0;
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 32'h0;
            cnt        = cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        br_taken = 1'b0;
        stall = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #3;
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_valid", {31'h0, if_valid}, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_inst", if_inst, 32'h0);
        check("rst_state", {30'h0, dbg_state}, {30'h0, ST_IDLE});

        // 1: zero-wait streaming, then redirect coinciding with an ack
        lat = 1;
        do_reset();
        tick();
        check("t1_req", {31'h0, imem_req}, 32'h1);
        check("t1_addr0", imem_addr, 32'h0);
        check("t1_valid0", {31'h0, if_valid}, 32'h0);
        tick();
        check("t1_valid", {31'h0, if_valid}, 32'h1);
        check("t1_if_pc0", if_pc, 32'h0);
        check("t1_inst0", if_inst, mem(32'h0));
        check("t1_addr4", imem_addr, 32'h4);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("t1_if_pc", if_pc, 32'(4 * k));
            check("t1_addr", imem_addr, 32'(4 * k + 4));
            check("t1_valid_k", {31'h0, if_valid}, 32'h1);
        end
        br_taken = 1'b1;
        br_target = 32'h0000_0080;
        #1;
        check("t1_flush_ifid", {31'h0, flush_ifid}, 32'h1);
        tick();
        br_taken = 1'b0;
        check("t1_br_state", {30'h0, dbg_state}, {30'h0, ST_REQ});
        check("t1_br_addr", imem_addr, 32'h80);
        check("t1_br_valid", {31'h0, if_valid}, 32'h0);
        tick();
        check("t1_br_if_pc", if_pc, 32'h80);
        check("t1_br_inst", if_inst, mem(32'h80));

        // 2: ack latency 3
        lat = 3;
        do_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t2_addr_a", imem_addr, 32'(4 * i));
            tick();
            check("t2_bubble1", {31'h0, if_valid}, 32'h0);
            check("t2_addr_b", imem_addr, 32'(4 * i));
            tick();
            check("t2_bubble2", {31'h0, if_valid}, 32'h0);
            check("t2_addr_c", imem_addr, 32'(4 * i));
            tick();
            check("t2_valid", {31'h0, if_valid}, 32'h1);
            check("t2_if_pc", if_pc, 32'(4 * i));
        end

        // 3: stall while the ack of 0x8 arrives
        lat = 1;
        do_reset();
        tick();
        tick();
        tick();
        check("t3_if_pc4", if_pc, 32'h4);
        stall = 1'b1;
        tick();
        check("t3_hold", {30'h0, dbg_state}, {30'h0, ST_HOLD});
        check("t3_req0", {31'h0, imem_req}, 32'h0);
        check("t3_if_pc_held", if_pc, 32'h4);
        check("t3_pc", pc, 32'hC);
        tick();
        check("t3_req0b", {31'h0, imem_req}, 32'h0);
        check("t3_if_pc_held2", if_pc, 32'h4);
        stall = 1'b0;
        tick();
        check("t3_rel_if_pc", if_pc, 32'h8);
        check("t3_rel_inst", if_inst, mem(32'h8));
        check("t3_rel_addr", imem_addr, 32'hC);
        check("t3_rel_state", {30'h0, dbg_state}, {30'h0, ST_REQ});
        tick();
        check("t3_next_if_pc", if_pc, 32'hC);

        // 4: redirect with 0x10 outstanding, latency 2
        lat = 2;
        do_reset();
        for (int i = 0; i < 9; i++) tick();
        check("t4_if_pc", if_pc, 32'hC);
        check("t4_addr10", imem_addr, 32'h10);
        @(negedge clk);
        #1;
        br_taken = 1'b1;
        br_target = 32'h0000_0100;
        #1;
        check("t4_flush_ifid", {31'h0, flush_ifid}, 32'h1);
        check("t4_flush_idex", {31'h0, flush_idex}, 32'h1);
        tick();
        br_taken = 1'b0;
        #1;
        check("t4_flush_off", {31'h0, flush_ifid}, 32'h0);
        check("t4_drop", {30'h0, dbg_state}, {30'h0, ST_DROP});
        check("t4_drop_addr", imem_addr, 32'h10);
        check("t4_drop_req", {31'h0, imem_req}, 32'h1);
        check("t4_drop_pc", pc, 32'h100);
        check("t4_drop_valid", {31'h0, if_valid}, 32'h0);
        tick();
        check("t4_req_state", {30'h0, dbg_state}, {30'h0, ST_REQ});
        check("t4_new_addr", imem_addr, 32'h100);
        check("t4_no_stale", {31'h0, if_valid}, 32'h0);
        tick();
        check("t4_no_stale2", {31'h0, if_valid}, 32'h0);
        tick();
        check("t4_tgt_valid", {31'h0, if_valid}, 32'h1);
        check("t4_tgt_if_pc", if_pc, 32'h100);

        // 5: redirect and stall together while in HOLD
        lat = 1;
        do_reset();
        tick();
        tick();
        tick();
        stall = 1'b1;
        tick();
        check("t5_hold", {30'h0, dbg_state}, {30'h0, ST_HOLD});
        br_taken = 1'b1;
        br_target = 32'h0000_0203;
        #1;
        check("t5_flush", {31'h0, flush_idex}, 32'h1);
        tick();
        br_taken = 1'b0;
        stall = 1'b0;
        check("t5_addr", imem_addr, 32'h200);
        check("t5_req", {31'h0, imem_req}, 32'h1);
        check("t5_valid0", {31'h0, if_valid}, 32'h0);
        tick();
        check("t5_if_pc", if_pc, 32'h200);
        check("t5_inst", if_inst, mem(32'h200));

        // 6: PC wrap, then reset while in DROP
        lat = 1;
        do_reset();
        br_taken = 1'b1;
        br_target = 32'hFFFF_FFFF;
        tick();
        br_taken = 1'b0;
        check("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
        tick();
        check("t6_if_pc_top", if_pc, 32'hFFFF_FFFC);
        check("t6_wrap_addr", imem_addr, 32'h0);
        lat = 3;
        @(negedge clk);
        #1;
        br_taken = 1'b1;
        br_target = 32'h0000_0040;
        tick();
        br_taken = 1'b0;
        check("t6_drop", {30'h0, dbg_state}, {30'h0, ST_DROP});
        check("t6_drop_addr", imem_addr, 32'h0);
        check("t6_drop_pc", pc, 32'h40);
        rstn = 1'b0;
        #1;
        check("t6_rst_req", {31'h0, imem_req}, 32'h0);
        check("t6_rst_pc", pc, 32'h0);
        check("t6_rst_valid", {31'h0, if_valid}, 32'h0);
        check("t6_rst_state", {30'h0, dbg_state}, {30'h0, ST_IDLE});
        tick();
        rstn = 1'b1;
        tick();
        check("t6_restart_state", {30'h0, dbg_state}, {30'h0, ST_REQ});
        check("t6_restart_addr", imem_addr, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
